// File: rtl/adder_station_if.sv
// Issue, operand-fetch and CDB signal bundle between the ROB side (master)
// and one adder reservation station (slave).
interface adder_station_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX  = 4
);
  logic [FU_INDEX-1:0]          CDB_inst_fu;
  logic [WORD_SIZE-1:0]         CDB_inst_inst;
  logic [RB_INDEX-1:0]          CDB_inst_RBindex;
  logic                         busy;
  logic [REG_INDEX-1:0]         numj;
  logic [REG_INDEX-1:0]         numk;
  logic [WORD_SIZE-1:0]         vj;
  logic [WORD_SIZE-1:0]         vk;
  logic [RB_INDEX:0]            qj;
  logic [RB_INDEX:0]            qk;
  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_o;
  logic [RB_SIZE-1:0]           CDB_data_valid_o;
  logic                         ovf;

  modport master (
    output CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
    output vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
    input  busy, numj, numk, CDB_data_data_o, CDB_data_valid_o, ovf
  );

  modport slave (
    input  CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
    input  vj, vk, qj, qk, CDB_data_data, CDB_data_valid,
    output busy, numj, numk, CDB_data_data_o, CDB_data_valid_o, ovf
  );
endinterface

// File: rtl/adder_station.sv
// One reservation station plus integer adder FU answering the ROB issue bus.
// Define ADDER_OVF_EN for signed-overflow detection with saturation.
module adder_station #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX  = 4,
  parameter int FU_NUM    = 16,
  parameter int FU_ID     = 0,
  parameter int EXEC_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FU_NUM-1:0] kill,
  adder_station_if.slave    bus
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [RB_INDEX:0] READY = '1;
  localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, DONE} state_t;

  state_t                       state;
  logic                         is_sub;
  logic [RB_INDEX-1:0]          rb_idx;
  logic [RB_INDEX-1:0]          tag_j;
  logic [RB_INDEX-1:0]          tag_k;
  logic                         pend_j;
  logic                         pend_k;
  logic [WORD_SIZE-1:0]         op_a;
  logic [WORD_SIZE-1:0]         op_b;
  logic [CW-1:0]                cnt;
  logic [RB_SIZE-1:0]           valid_o;
  logic [RB_SIZE*WORD_SIZE-1:0] data_o;

  logic [3:0]           inst_op;
  logic [12:0]          inst_imm;
  logic                 imm_op;
  logic                 issue;
  logic [WORD_SIZE-1:0] imm_ext;
  logic                 j_ready, k_ready, j_snoop, k_snoop, j_pend, k_pend;
  logic [WORD_SIZE-1:0] j_val, k_val;
  logic                 j_hit, k_hit;
  logic [WORD_SIZE-1:0] b_eff, sum, result;
  logic                 unused_bits;

  function automatic logic [WORD_SIZE-1:0] slot(input logic [RB_SIZE*WORD_SIZE-1:0] vec,
                                                input logic [RB_INDEX-1:0] idx);
    return vec[idx*WORD_SIZE +: WORD_SIZE];
  endfunction

  assign inst_op  = bus.CDB_inst_inst[31:28];
  assign inst_imm = bus.CDB_inst_inst[12:0];
  assign imm_ext  = {{(WORD_SIZE-13){inst_imm[12]}}, inst_imm};
  assign imm_op   = (inst_op == OP_ADDI) || (inst_op == OP_SUBI);
  assign issue    = (bus.CDB_inst_fu == FU_INDEX'(FU_ID)) &&
                    ((inst_op == OP_ADD) || (inst_op == OP_SUB) || imm_op);
  assign bus.numj = bus.CDB_inst_inst[22:18];
  assign bus.numk = bus.CDB_inst_inst[17:13];
  assign unused_bits = ^{kill, bus.CDB_inst_inst[27:23]};

  // An operand not in the register file may be on the CDB in the very issue cycle.
  assign j_ready = (bus.qj == READY);
  assign k_ready = (bus.qk == READY);
  assign j_snoop = bus.CDB_data_valid[bus.qj[RB_INDEX-1:0]];
  assign k_snoop = bus.CDB_data_valid[bus.qk[RB_INDEX-1:0]];
  assign j_val   = j_ready ? bus.vj : slot(bus.CDB_data_data, bus.qj[RB_INDEX-1:0]);
  assign k_val   = imm_op ? imm_ext :
                   (k_ready ? bus.vk : slot(bus.CDB_data_data, bus.qk[RB_INDEX-1:0]));
  assign j_pend  = !j_ready && !j_snoop;
  assign k_pend  = !imm_op && !k_ready && !k_snoop;

  assign j_hit = pend_j && bus.CDB_data_valid[tag_j];
  assign k_hit = pend_k && bus.CDB_data_valid[tag_k];

  assign b_eff = is_sub ? (~op_b + 1'b1) : op_b;
  assign sum   = op_a + b_eff;

`ifdef ADDER_OVF_EN
  logic overflow;
  logic ovf_r;
  assign overflow = (op_a[WORD_SIZE-1] == b_eff[WORD_SIZE-1]) &&
                    (sum[WORD_SIZE-1] != op_a[WORD_SIZE-1]);
  assign result   = !overflow ? sum :
                    (op_a[WORD_SIZE-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                       : {1'b0, {(WORD_SIZE-1){1'b1}}});
  assign bus.ovf  = ovf_r;
`else
  assign result  = sum;
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy             = (state != IDLE);
  assign bus.CDB_data_valid_o = valid_o;
  assign bus.CDB_data_data_o  = data_o;

  // A kill of this FU squashes the in-flight op asynchronously, same as reset.
  always_ff @(posedge clk or posedge reset or posedge kill[FU_ID]) begin
    if (reset || kill[FU_ID]) begin
      state   <= IDLE;
      is_sub  <= 1'b0;
      rb_idx  <= '0;
      tag_j   <= '0;
      tag_k   <= '0;
      pend_j  <= 1'b0;
      pend_k  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      valid_o <= '0;
      data_o  <= '0;
`ifdef ADDER_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            is_sub <= (inst_op == OP_SUB) || (inst_op == OP_SUBI);
            rb_idx <= bus.CDB_inst_RBindex;
            op_a   <= j_val;
            op_b   <= k_val;
            tag_j  <= bus.qj[RB_INDEX-1:0];
            tag_k  <= bus.qk[RB_INDEX-1:0];
            pend_j <= j_pend;
            pend_k <= k_pend;
            if (j_pend || k_pend) begin
              state <= WAIT_OPS;
            end else begin
              state <= EXEC;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT_OPS: begin
          if (j_hit) begin
            op_a   <= slot(bus.CDB_data_data, tag_j);
            pend_j <= 1'b0;
          end
          if (k_hit) begin
            op_b   <= slot(bus.CDB_data_data, tag_k);
            pend_k <= 1'b0;
          end
          if ((!pend_j || j_hit) && (!pend_k || k_hit)) begin
            state <= EXEC;
            cnt   <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state   <= DONE;
            valid_o <= RB_SIZE'(1) << rb_idx;
            data_o  <= (RB_SIZE*WORD_SIZE)'(result) << (rb_idx * WORD_SIZE);
`ifdef ADDER_OVF_EN
            ovf_r   <= overflow;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= '0;
          data_o  <= '0;
`ifdef ADDER_OVF_EN
          ovf_r   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_station.sv
// Scoreboard bench for adder_station: expected results are queued at issue
// and popped when the station drives its CDB slot.
module tb_adder_station;
  localparam int W    = 32;
  localparam int RBS  = 8;
  localparam int RBI  = 3;
  localparam int REGI = 5;
  localparam int FUI  = 4;
  localparam int FUN  = 16;
  localparam int LAT  = 2;
  localparam logic [RBI:0] READY = '1;

  logic           clk = 1'b0;
  logic           reset;
  logic [FUN-1:0] kill;

  adder_station_if #(.WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI),
                     .REG_INDEX(REGI), .FU_INDEX(FUI)) bus();

  adder_station #(.WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI), .REG_INDEX(REGI),
                  .FU_INDEX(FUI), .FU_NUM(FUN), .FU_ID(0), .EXEC_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .kill  (kill),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RBI-1:0] rb;
    logic [W-1:0]   data;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [W-1:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [12:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic idle_bus();
    bus.CDB_inst_fu      = 4'hF;
    bus.CDB_inst_inst    = '0;
    bus.CDB_inst_RBindex = '0;
    bus.vj               = '0;
    bus.vk               = '0;
    bus.qj               = READY;
    bus.qk               = READY;
    bus.CDB_data_data    = '0;
    bus.CDB_data_valid   = '0;
  endtask

  // Drive one issue once the station is free; returns at the negedge after the issue edge.
  task automatic applyStimulus(input logic [W-1:0] inst, input logic [RBI-1:0] rb,
                               input logic [W-1:0] vj, input logic [W-1:0] vk,
                               input logic [RBI:0] qj, input logic [RBI:0] qk);
    int n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.CDB_inst_fu      = 4'h0;
    bus.CDB_inst_inst    = inst;
    bus.CDB_inst_RBindex = rb;
    bus.vj = vj;
    bus.vk = vk;
    bus.qj = qj;
    bus.qk = qk;
    @(posedge clk);
    @(negedge clk);
    bus.CDB_inst_fu = 4'hF;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (bus.CDB_data_valid_o == '0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.CDB_data_valid_o == '0) cycles = -1;
  endtask

  task automatic test_reset();
    exp_t e;
    int cyc;
    logic [RBS-1:0]   exp_v;
    logic [RBS*W-1:0] exp_d;
    idle_bus();
    kill  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.CDB_data_valid_o !== '0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", bus.CDB_data_valid_o); end
    n_checks++; if (bus.CDB_data_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", bus.CDB_data_data_o); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
    reset = 1'b0;
    @(negedge clk);
    bus.CDB_inst_inst = enc(4'h0, 5'd3, 5'd1, 5'd2, 13'd0);
    #1;
    n_checks++; if (bus.numj !== 5'd1 || bus.numk !== 5'd2) begin n_fail++; $display("[TB] FAIL numjk: got %0d/%0d want 1/2", bus.numj, bus.numk); end
    @(negedge clk);
    sb.push_back('{rb: 3'd2, data: 32'd12, ovf: 1'b0});
    applyStimulus(enc(4'h0, 5'd3, 5'd1, 5'd2, 13'd0), 3'd2, 32'd5, 32'd7, READY, READY);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL add_busy_after_issue: got %b want 1", bus.busy); end
    wait_valid(cyc);
    e = sb.pop_front();
    exp_v = '0; exp_v[e.rb] = 1'b1;
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL add_latency: got %0d want %0d", cyc, LAT); end
    n_checks++; if (bus.CDB_data_valid_o !== exp_v) begin n_fail++; $display("[TB] FAIL add_valid: got %b want %b", bus.CDB_data_valid_o, exp_v); end
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL add_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL add_busy_done: got %b want 1", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.CDB_data_valid_o !== '0) begin n_fail++; $display("[TB] FAIL add_release: busy %b valid %b want 0/0", bus.busy, bus.CDB_data_valid_o); end
  endtask

  task automatic test_subi();
    exp_t e;
    int cyc;
    logic [RBS*W-1:0] exp_d;
    sb.push_back('{rb: 3'd7, data: 32'd13, ovf: 1'b0});
    applyStimulus(enc(4'h6, 5'd4, 5'd1, 5'd0, 13'h1FFD), 3'd7, 32'd10, 32'hDEAD_BEEF, READY, 4'd5);
    wait_valid(cyc);
    e = sb.pop_front();
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL subi_latency: got %0d want %0d", cyc, LAT); end
    n_checks++; if (bus.CDB_data_valid_o !== 8'b1000_0000) begin n_fail++; $display("[TB] FAIL subi_valid: got %b want 10000000", bus.CDB_data_valid_o); end
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL subi_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_pending();
    exp_t e;
    int cyc;
    logic [RBS*W-1:0] exp_d;
    sb.push_back('{rb: 3'd5, data: 32'd18, ovf: 1'b0});
    applyStimulus(enc(4'h0, 5'd6, 5'd7, 5'd8, 13'd0), 3'd5, 32'h0000_DEAD, 32'h0000_BEEF, 4'd4, 4'd4);
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.CDB_data_valid_o !== '0) begin n_fail++; $display("[TB] FAIL pend_wait: busy %b valid %b want 1/0", bus.busy, bus.CDB_data_valid_o); end
    bus.CDB_data_valid    = 8'b0001_0000;
    bus.CDB_data_data[4*W +: W] = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.CDB_data_valid = '0;
    bus.CDB_data_data  = '0;
    wait_valid(cyc);
    e = sb.pop_front();
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL pend_latency: got %0d want %0d", cyc, LAT); end
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL pend_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_snoop();
    exp_t e;
    int cyc;
    logic [RBS*W-1:0] exp_d;
    sb.push_back('{rb: 3'd3, data: 32'd21, ovf: 1'b0});
    bus.CDB_data_valid    = 8'b0000_0010;
    bus.CDB_data_data[1*W +: W] = 32'd20;
    applyStimulus(enc(4'h0, 5'd9, 5'd10, 5'd11, 13'd0), 3'd3, 32'h0BAD_0BAD, 32'd1, 4'd1, READY);
    bus.CDB_data_valid = '0;
    bus.CDB_data_data  = '0;
    wait_valid(cyc);
    e = sb.pop_front();
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL snoop_latency: got %0d want %0d", cyc, LAT); end
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL snoop_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_kill();
    exp_t e;
    int cyc;
    int seen = 0;
    logic [RBS*W-1:0] exp_d;
    applyStimulus(enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0), 3'd6, 32'd1, 32'd2, READY, READY);
    kill = 16'h0001;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL kill_busy: got %b want 0", bus.busy); end
    #1;
    kill = '0;
    repeat (5) begin
      @(negedge clk);
      if (bus.CDB_data_valid_o != '0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL kill_no_valid: got %0d valid cycles want 0", seen); end
    sb.push_back('{rb: 3'd1, data: 32'd123, ovf: 1'b0});
    applyStimulus(enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0), 3'd1, 32'd100, 32'd23, READY, READY);
    wait_valid(cyc);
    e = sb.pop_front();
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL kill_next_latency: got %0d want %0d", cyc, LAT); end
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL kill_next_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    bus.CDB_inst_fu   = 4'h0;
    bus.CDB_inst_inst = enc(4'h3, 5'd1, 5'd2, 5'd3, 13'd0);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_badop: busy %b want 0", bus.busy); end
    bus.CDB_inst_fu   = 4'h2;
    bus.CDB_inst_inst = enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0);
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_otherfu: busy %b want 0", bus.busy); end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    logic [RBS*W-1:0] exp_d;
    logic [3:0]       op;
    logic [W-1:0]     a, b, r;
    for (int i = 0; i < 6; i++) begin
      op = (i % 3 == 0) ? 4'h0 : ((i % 3 == 1) ? 4'h1 : 4'h5);
      a  = W'($urandom_range(0, 100000));
      b  = W'($urandom_range(0, 4095));
      r  = (op == 4'h1) ? a - b : a + b;
      sb.push_back('{rb: RBI'(i), data: r, ovf: 1'b0});
      applyStimulus(enc(op, 5'd1, 5'd2, 5'd3, b[12:0]), RBI'(i), a,
                    (op == 4'h5) ? 32'hFFFF_0000 : b, READY, READY);
      wait_valid(cyc);
      e = sb.pop_front();
      exp_d = '0; exp_d[e.rb*W +: W] = e.data;
      n_checks++; if (cyc !== LAT) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, LAT); end
      n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, bus.CDB_data_data_o, exp_d); end
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_release[%0d]: busy %b want 0", i, bus.busy); end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int cyc;
    logic [RBS*W-1:0] exp_d;
`ifdef ADDER_OVF_EN
    sb.push_back('{rb: 3'd0, data: 32'h7FFF_FFFF, ovf: 1'b1});
`else
    sb.push_back('{rb: 3'd0, data: 32'h8000_0000, ovf: 1'b0});
`endif
    applyStimulus(enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0), 3'd0, 32'h7FFF_FFFF, 32'd1, READY, READY);
    wait_valid(cyc);
    e = sb.pop_front();
    exp_d = '0; exp_d[e.rb*W +: W] = e.data;
    n_checks++; if (bus.CDB_data_data_o !== exp_d) begin n_fail++; $display("[TB] FAIL ovf_data: got %h want %h", bus.CDB_data_data_o, exp_d); end
    n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b want %b", bus.ovf, e.ovf); end
    @(negedge clk);
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b want 0", bus.ovf); end
  endtask

  initial begin
    test_reset();
    test_subi();
    test_pending();
    test_snoop();
    test_kill();
    test_ignore();
    test_back_to_back();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
